synchronous_fifo: RTL and testbench

// - Single-clock FIFO buffer used between pipeline stages of the core (e.g. fetch->issue queues).
// - Stores DEPTH words of WIDTH bits and reports occupancy, threshold and error flags.
// - Frozen (no push/pop accepted, no state change) while global enable en is low.

---
 rtl/synchronous_fifo.sv | 112 +++++++++++
 tb/tb_synchronous_fifo.sv | 132 +++++++++++++
 2 files changed

// File: rtl/synchronous_fifo.sv
// synchronous_fifo: single-clock FIFO with occupancy, threshold and error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module synchronous_fifo #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             afull_q, afull_d, aempty_q, aempty_d;
    logic             overflow_q, overflow_d, underflow_q, underflow_d;
    logic             push, pop;

    // A push into a full FIFO is fine when a pop frees a slot in the same cycle.
    always_comb begin
        pop         = en && rd_en && !empty_q;
        push        = en && wr_en && (!full_q || pop);
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        full_d      = int'(count_d) == DEPTH;
        empty_d     = count_d == '0;
        afull_d     = int'(count_d) >= AFULL_THRESH;
        aempty_d    = int'(count_d) <= AEMPTY_THRESH;
        overflow_d  = en && wr_en && !push;
        underflow_d = en && rd_en && !pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= AFULL_THRESH == 0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = !empty_q;
`else
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    always_comb begin
        rd_data_d  = pop ? mem_q[rd_ptr_q] : rd_data_q;
        rd_valid_d = pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
endmodule

// File: tb/tb_synchronous_fifo.sv
// tb_synchronous_fifo: directed checks of the default registered-read synchronous_fifo.
module tb_synchronous_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0]  count;
    int          checks = 0;
    int          errors = 0;

    synchronous_fifo dut (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic [31:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_afull", almost_full, 0);
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1, 32'(i * 'h11), 0);
            chk("fill_count", count, i);
            chk("fill_full", full, i == 8);
            chk("fill_afull", almost_full, i >= 7);
            chk("fill_aempty", almost_empty, i <= 1);
            chk("fill_empty", empty, 0);
        end
        step(1, 32'h99, 0);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 8);
        step(0, 0, 0);
        chk("ovf_clear", overflow, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1);
            chk("drain_valid", rd_valid, 1);
            chk("drain_data", rd_data, i * 'h11);
            chk("drain_count", count, 8 - i);
        end
        chk("drain_empty", empty, 1);
        step(0, 0, 1);
        chk("udf_pulse", underflow, 1);
        chk("udf_valid", rd_valid, 0);
        chk("udf_hold_data", rd_data, 'h88);
        chk("udf_count", count, 0);
        step(0, 0, 0);
        chk("udf_clear", underflow, 0);
        for (int i = 1; i <= 8; i++) step(1, 32'(i * 'h11), 0);
        step(1, 32'hAA, 1);
        chk("simfull_count", count, 8);
        chk("simfull_full", full, 1);
        chk("simfull_ovf", overflow, 0);
        chk("simfull_data", rd_data, 'h11);
        for (int i = 2; i <= 9; i++) begin
            step(0, 0, 1);
            chk("simfull_drain", rd_data, i == 9 ? 'hAA : i * 'h11);
        end
        chk("simfull_empty", empty, 1);
        step(1, 32'hBB, 1);
        chk("simempty_count", count, 1);
        chk("simempty_udf", underflow, 1);
        chk("simempty_valid", rd_valid, 0);
        step(0, 0, 1);
        chk("simempty_data", rd_data, 'hBB);
        chk("simempty_after", count, 0);
        step(1, 32'h01, 0);
        step(1, 32'h02, 0);
        en = 1'b0;
        step(1, 32'h03, 1);
        chk("en0_count", count, 2);
        chk("en0_valid", rd_valid, 0);
        chk("en0_ovf", overflow, 0);
        chk("en0_udf", underflow, 0);
        chk("en0_hold_data", rd_data, 'hBB);
        en = 1'b1;
        step(0, 0, 1);
        chk("en1_pop1", rd_data, 'h01);
        step(0, 0, 1);
        chk("en1_pop2", rd_data, 'h02);
        chk("en1_empty", empty, 1);
        step(1, 32'h100, 0);
        for (int i = 1; i <= 20; i++) begin
            step(1, 32'h100 + 32'(i), 1);
            chk("wrap_data", rd_data, 'h100 + i - 1);
            chk("wrap_count", count, 1);
        end
        step(1, 32'h200, 0);
        step(1, 32'h201, 0);
        chk("pre_reset_count", count, 3);
        rst = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_empty", empty, 1);
        chk("async_rst_data", rd_data, 0);
        step(0, 0, 0);
        rst = 1'b1;
        step(0, 0, 1);
        chk("post_rst_udf", underflow, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
